dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: DATA_W, 16, data width of both requesters and the memory port.
REQ-002 Parameter: ADDR_W, 16, address width of both requesters and the memory port.
REQ-003 Parameter: MAX_BURST, 8, maximum number of consecutive locked grants to port 1 (legal range 1..255).
REQ-004 clk  in  1  single clock; all state changes on the rising edge.
REQ-005 rst  in  1  reset, asynchronous assert, active-low (0 = reset).
REQ-006 p0_req  in  1  port 0 (CPU data port) access request.
REQ-007 p0_we  in  1  port 0 write enable (1 = write, 0 = read).
REQ-008 p0_addr  in  ADDR_W  port 0 address.
REQ-009 p0_wdata  in  DATA_W  port 0 write data.
REQ-010 p0_gnt  out  1  port 0 access issued this cycle.
REQ-011 p0_stall  out  1  equals p0_req & ~p0_gnt.
REQ-012 p0_rvalid  out  1  port 0 read data valid.
REQ-013 p0_rdata  out  DATA_W  port 0 read data.
REQ-014 p1_req, p1_we, p1_addr, p1_wdata  in  1/1/ADDR_W/DATA_W  port 1 (DMA/debug) request fields, same meaning as port 0.
REQ-015 p1_lock  in  1  port 1 requests burst ownership.
REQ-016 p1_gnt, p1_rvalid, p1_rdata  out  1/1/DATA_W  port 1 grant and response.
REQ-017 mem_addr, mem_wdata, mem_we  out  ADDR_W/DATA_W/1  single-port synchronous RAM request.
REQ-018 mem_rdata  in  DATA_W  RAM read data, valid one cycle after the read was issued.

Function
REQ-019 At most one of p0_gnt and p1_gnt SHALL be 1 in any cycle; grant is combinational from the current requests and state.
REQ-020 With only one port requesting, that port SHALL be granted in the same cycle, subject to REQ-023.
REQ-021 With both ports requesting and no active lock, the port not granted most recently SHALL win (round-robin); last_gnt resets to 1, so port 0 wins the first tie.
REQ-022 last_gnt SHALL update on every cycle in which a grant is issued.
REQ-023 Lock: a p1 grant with p1_lock=1 SHALL enter state LOCKED; while LOCKED, p1 SHALL win every tie, and p0 SHALL be granted only when p1_req=0.
REQ-024 burst_cnt SHALL count locked p1 grants, starting at 1 on entry to LOCKED.
REQ-025 LOCKED -> OPEN SHALL occur on p1_lock=0 or when burst_cnt reaches MAX_BURST; after a MAX_BURST exit, p0 SHALL win the next tie, and p1 SHALL NOT re-enter LOCKED until after a p0 grant or an idle cycle.
REQ-026 The memory port SHALL carry the granted port's addr/wdata/we; mem_we SHALL be 0 when there is no grant or when the granted access is a read.
REQ-027 With no grant, mem_addr and mem_wdata SHALL hold their last values (no toggling).
REQ-028 A granted read SHALL register a response tag (valid, owner); in the next cycle pX_rvalid=1 for that owner only and pX_rdata=mem_rdata.
REQ-029 Writes SHALL produce no rvalid.
REQ-030 Back-to-back reads from alternating ports SHALL yield one rvalid per cycle, each returned to the correct owner.
REQ-031 pX_rdata SHALL hold its last valid value when pX_rvalid=0.
REQ-032 A port that deasserts req without being granted SHALL have no side effect.

Reset
REQ-033 While rst=0, all grants, rvalids and mem_we SHALL be 0; mem_addr, mem_wdata, p0_rdata and p1_rdata SHALL be 0; state=OPEN; burst_cnt=0; last_gnt=1.
REQ-034 Reset asserted mid-operation SHALL drop any pending response: no rvalid in the first cycle after rst deasserts.
REQ-035 The first arbitration after reset release SHALL follow REQ-021.

Verification
REQ-036 p0 read at 0x0010 alone with RAM[0x0010]=0xBEEF -> p0_gnt=1 at cycle 0; p0_rvalid=1 and p0_rdata=0xBEEF at cycle 1; p1 outputs stay 0.
REQ-037 Both ports request reads for 4 cycles without lock -> grants alternate p0,p1,p0,p1; p0_stall=1 on cycles 1 and 3; each rvalid goes only to its owner.
REQ-038 p1_lock=1 and both ports requesting continuously, MAX_BURST=8 -> p1 is granted 8 consecutive times, then p0 is granted on the 9th cycle.
REQ-039 Same-cycle p0 write 0x1234 to 0x0020 with a p1 read of 0x0020 after reset -> p0 wins; the p1 read issues next cycle and returns 0x1234.
REQ-040 p0 read granted, then rst=0 during the following cycle -> no p0_rvalid; all outputs are 0 during reset and after release.
REQ-041 Idle with no requests for 10 cycles -> mem_we=0; mem_addr stable; no grants or rvalids asserted.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter in front of a single-port synchronous RAM.
//   Port 0 (CPU) and port 1 (DMA/debug) each present req/we/addr/wdata and
//   receive a same-cycle grant plus a next-cycle read response (rvalid/rdata).
//   Ties go round-robin. Port 1 can hold a burst lock of up to MAX_BURST
//   grants. The mem_* outputs drive the RAM; mem_rdata returns one cycle
//   after a read is issued.
//   clk, rst (async, active-low).
module dmem_arbiter #(
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_stall,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic              p1_lock,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic {ST_OPEN, ST_LOCKED} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic              last_gnt_q, last_gnt_d;    // 1 = port 1 was granted most recently
  logic              no_relock_q, no_relock_d;  // blocks re-lock after a full burst
  logic              rsp_valid_q, rsp_owner_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] p0_rdata_q, p1_rdata_q;

  // Arbitration and lock state machine; grants are forced off while in reset.
  always_comb begin
    p0_gnt      = 1'b0;
    p1_gnt      = 1'b0;
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    last_gnt_d  = last_gnt_q;
    no_relock_d = no_relock_q;

    if (rst) begin
      if (p0_req && p1_req) begin
        if (state_q == ST_LOCKED) p1_gnt = 1'b1;
        else if (last_gnt_q)      p0_gnt = 1'b1;
        else                      p1_gnt = 1'b1;
      end else begin
        p0_gnt = p0_req;
        p1_gnt = p1_req;
      end
    end

    if (p0_gnt) last_gnt_d = 1'b0;
    if (p1_gnt) last_gnt_d = 1'b1;

    // A p0 grant or an idle cycle re-arms the lock.
    if (!p1_gnt) no_relock_d = 1'b0;

    case (state_q)
      ST_OPEN: begin
        if (p1_gnt && p1_lock && !no_relock_q) begin
          if (MAX_BURST <= 1) begin
            no_relock_d = 1'b1;
          end else begin
            state_d     = ST_LOCKED;
            burst_cnt_d = CNT_W'(1);
          end
        end
      end
      ST_LOCKED: begin
        if (!p1_lock) begin
          state_d     = ST_OPEN;
          burst_cnt_d = '0;
        end else if (p1_gnt) begin
          if (burst_cnt_q == CNT_W'(MAX_BURST - 1)) begin
            state_d     = ST_OPEN;
            burst_cnt_d = '0;
            no_relock_d = 1'b1;
          end else begin
            burst_cnt_d = burst_cnt_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d     = ST_OPEN;
        burst_cnt_d = '0;
      end
    endcase
  end

  // Memory request mux; address/data hold their last value when idle.
  always_comb begin
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    mem_we    = 1'b0;
    if (p0_gnt) begin
      mem_addr  = p0_addr;
      mem_wdata = p0_wdata;
      mem_we    = p0_we;
    end else if (p1_gnt) begin
      mem_addr  = p1_addr;
      mem_wdata = p1_wdata;
      mem_we    = p1_we;
    end
  end

  assign p0_stall  = p0_req & ~p0_gnt;
  assign p0_rvalid = rsp_valid_q & ~rsp_owner_q;
  assign p1_rvalid = rsp_valid_q &  rsp_owner_q;
  // RAM data is live during the response cycle and captured for holding.
  assign p0_rdata  = p0_rvalid ? mem_rdata : p0_rdata_q;
  assign p1_rdata  = p1_rvalid ? mem_rdata : p1_rdata_q;

  // State, response tag and hold registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_OPEN;
      burst_cnt_q <= '0;
      last_gnt_q  <= 1'b1;
      no_relock_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_owner_q <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      p0_rdata_q  <= '0;
      p1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      last_gnt_q  <= last_gnt_d;
      no_relock_q <= no_relock_d;
      rsp_valid_q <= (p0_gnt & ~p0_we) | (p1_gnt & ~p1_we);
      rsp_owner_q <= p1_gnt;
      if (p0_gnt || p1_gnt) begin
        addr_q  <= mem_addr;
        wdata_q <= mem_wdata;
      end
      if (p0_rvalid) p0_rdata_q <= mem_rdata;
      if (p1_rvalid) p1_rdata_q <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: vector table plus read-response scoreboard,
// with hand-written reset and idle sequences.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        p0_req = 1'b0, p0_we = 1'b0;
  logic [15:0] p0_addr = '0, p0_wdata = '0;
  logic        p0_gnt, p0_stall, p0_rvalid;
  logic [15:0] p0_rdata;
  logic        p1_req = 1'b0, p1_we = 1'b0, p1_lock = 1'b0;
  logic [15:0] p1_addr = '0, p1_wdata = '0;
  logic        p1_gnt, p1_rvalid;
  logic [15:0] p1_rdata;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_we;
  logic [15:0] mem_rdata = '0;

  dmem_arbiter #(.DATA_W(16), .ADDR_W(16), .MAX_BURST(8)) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_stall(p0_stall), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_lock(p1_lock), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM the arbiter drives.
  logic [15:0] ram [0:255];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[7:0]] <= mem_wdata;
    mem_rdata <= ram[mem_addr[7:0]];
  end

  typedef struct packed {
    logic        p0_req, p0_we;
    logic [15:0] p0_addr, p0_wdata;
    logic        p1_req, p1_we, p1_lock;
    logic [15:0] p1_addr, p1_wdata;
    logic        exp_g0, exp_g1;
  } vec_t;

  typedef struct packed {
    logic        owner;
    logic [15:0] data;
  } rsp_t;

  int          checks = 0;
  int          failures = 0;
  rsp_t        sb[$];
  logic [15:0] exp_mem [0:255];
  logic [15:0] exp_addr = '0, exp_wdata = '0, exp_rd0 = '0, exp_rd1 = '0;
  vec_t        tbl[$];

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic a_r, a_w, input logic [15:0] a_a, a_d,
                              input logic b_r, b_w, b_l, input logic [15:0] b_a, b_d,
                              input logic g0, g1);
    vec_t v;
    v.p0_req = a_r; v.p0_we = a_w; v.p0_addr = a_a; v.p0_wdata = a_d;
    v.p1_req = b_r; v.p1_we = b_w; v.p1_lock = b_l; v.p1_addr = b_a; v.p1_wdata = b_d;
    v.exp_g0 = g0; v.exp_g1 = g1;
    return v;
  endfunction

  // Drive one cycle at the falling edge, check mid-cycle, score reads.
  task automatic apply(input vec_t v, input int idx);
    rsp_t r;
    logic rv0, rv1;
    logic exp_we;
    @(negedge clk);
    p0_req = v.p0_req; p0_we = v.p0_we; p0_addr = v.p0_addr; p0_wdata = v.p0_wdata;
    p1_req = v.p1_req; p1_we = v.p1_we; p1_lock = v.p1_lock;
    p1_addr = v.p1_addr; p1_wdata = v.p1_wdata;
    #1;
    rv0 = 1'b0; rv1 = 1'b0;
    if (sb.size() > 0) begin
      r = sb.pop_front();
      if (r.owner) begin rv1 = 1'b1; exp_rd1 = r.data; end
      else         begin rv0 = 1'b1; exp_rd0 = r.data; end
    end
    exp_we = 1'b0;
    if (v.exp_g0) begin exp_we = v.p0_we; exp_addr = v.p0_addr; exp_wdata = v.p0_wdata; end
    else if (v.exp_g1) begin exp_we = v.p1_we; exp_addr = v.p1_addr; exp_wdata = v.p1_wdata; end
    chk($sformatf("v%0d p0_gnt", idx), 16'(p0_gnt), 16'(v.exp_g0));
    chk($sformatf("v%0d p1_gnt", idx), 16'(p1_gnt), 16'(v.exp_g1));
    chk($sformatf("v%0d p0_stall", idx), 16'(p0_stall), 16'(v.p0_req & ~v.exp_g0));
    chk($sformatf("v%0d mem_we", idx), 16'(mem_we), 16'(exp_we));
    chk($sformatf("v%0d mem_addr", idx), mem_addr, exp_addr);
    chk($sformatf("v%0d mem_wdata", idx), mem_wdata, exp_wdata);
    chk($sformatf("v%0d p0_rvalid", idx), 16'(p0_rvalid), 16'(rv0));
    chk($sformatf("v%0d p1_rvalid", idx), 16'(p1_rvalid), 16'(rv1));
    chk($sformatf("v%0d p0_rdata", idx), p0_rdata, exp_rd0);
    chk($sformatf("v%0d p1_rdata", idx), p1_rdata, exp_rd1);
    if (v.exp_g0 && !v.p0_we) sb.push_back({1'b0, exp_mem[v.p0_addr[7:0]]});
    if (v.exp_g1 && !v.p1_we) sb.push_back({1'b1, exp_mem[v.p1_addr[7:0]]});
    if (v.exp_g0 && v.p0_we) exp_mem[v.p0_addr[7:0]] = v.p0_wdata;
    if (v.exp_g1 && v.p1_we) exp_mem[v.p1_addr[7:0]] = v.p1_wdata;
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, " p0_gnt"}, 16'(p0_gnt), 16'h0);
    chk({nm, " p1_gnt"}, 16'(p1_gnt), 16'h0);
    chk({nm, " p0_rvalid"}, 16'(p0_rvalid), 16'h0);
    chk({nm, " p1_rvalid"}, 16'(p1_rvalid), 16'h0);
    chk({nm, " mem_we"}, 16'(mem_we), 16'h0);
    chk({nm, " mem_addr"}, mem_addr, 16'h0);
    chk({nm, " mem_wdata"}, mem_wdata, 16'h0);
    chk({nm, " p0_rdata"}, p0_rdata, 16'h0);
    chk({nm, " p1_rdata"}, p1_rdata, 16'h0);
  endtask

  initial begin
    vec_t idle;
    vec_t both_lk, both_nl;
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 16'hA000 + 16'(i);
      exp_mem[i] = 16'hA000 + 16'(i);
    end
    ram[16]     = 16'hBEEF;
    exp_mem[16] = 16'hBEEF;

    idle    = mk(0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0, 0, 0);
    both_lk = mk(1, 0, 16'h0040, 16'h0, 1, 0, 1, 16'h0041, 16'h0, 0, 0);
    both_nl = mk(1, 0, 16'h0050, 16'h0, 1, 0, 0, 16'h0051, 16'h0, 0, 0);

    // Single-port read of 0x0010, then a p1-only read.
    tbl.push_back(mk(1, 0, 16'h0010, 16'h0, 0, 0, 0, 16'h0, 16'h0, 1, 0));
    tbl.push_back(mk(0, 0, 16'h0, 16'h0, 1, 0, 0, 16'h0030, 16'h0, 0, 1));
    tbl.push_back(idle);
    // Four contended cycles without lock alternate p0,p1,p0,p1.
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(1, 0, 16'h0011 + 16'(2*i), 16'h0, 1, 0, 0, 16'h0012 + 16'(2*i), 16'h0,
                       (i % 2) == 0, (i % 2) == 1));
    // Same-cycle p0 write / p1 read to 0x0020; p1 read follows.
    tbl.push_back(mk(1, 1, 16'h0020, 16'h1234, 1, 0, 0, 16'h0020, 16'h0, 1, 0));
    tbl.push_back(mk(0, 0, 16'h0, 16'h0, 1, 0, 0, 16'h0020, 16'h0, 0, 1));
    tbl.push_back(idle);
    // Lock burst: p0 takes the first tie, then p1 holds for 8 grants.
    both_lk.exp_g0 = 1; both_lk.exp_g1 = 0; tbl.push_back(both_lk);
    both_lk.exp_g0 = 0; both_lk.exp_g1 = 1;
    for (int i = 0; i < 8; i++) tbl.push_back(both_lk);
    // After a full burst, p1 alone with lock must not re-lock; p0 wins the tie.
    tbl.push_back(mk(0, 0, 16'h0, 16'h0, 1, 0, 1, 16'h0042, 16'h0, 0, 1));
    both_lk.exp_g0 = 1; both_lk.exp_g1 = 0; tbl.push_back(both_lk);
    // Re-lock, then drop p1_lock: p1 still owns that cycle, then round-robin.
    both_lk.exp_g0 = 0; both_lk.exp_g1 = 1; tbl.push_back(both_lk);
    tbl.push_back(both_lk);
    both_lk.p1_lock = 0; tbl.push_back(both_lk);
    both_nl.exp_g0 = 1; both_nl.exp_g1 = 0; tbl.push_back(both_nl);
    both_nl.exp_g0 = 0; both_nl.exp_g1 = 1; tbl.push_back(both_nl);
    tbl.push_back(idle);

    // Reset state, with requests held to confirm grants are gated.
    p0_req = 1'b1; p1_req = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    p0_req = 1'b0; p1_req = 1'b0;
    rst = 1'b1;

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // p0 read granted, then reset asserted during the response cycle.
    apply(mk(1, 0, 16'h0010, 16'h0, 0, 0, 0, 16'h0, 16'h0, 1, 0), 100);
    p1_req = 1'b1;
    @(posedge clk);
    #2;
    rst = 1'b0;
    sb.delete();
    exp_addr = '0; exp_wdata = '0; exp_rd0 = '0; exp_rd1 = '0;
    #1;
    check_reset_outputs("mid_rst");
    @(negedge clk);
    #1;
    check_reset_outputs("in_rst");
    @(negedge clk);
    p0_req = 1'b0; p1_req = 1'b0;
    rst = 1'b1;
    apply(idle, 101);
    // First tie after release goes to p0.
    both_nl.exp_g0 = 1; both_nl.exp_g1 = 0;
    apply(both_nl, 102);
    // Ten idle cycles: no grants, no rvalid beyond the pending one, address held.
    for (int i = 0; i < 10; i++) apply(idle, 110 + i);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
